data_axil_master: RTL
=====================

// Module: data_axil_master
// PURPOSE
//  Data-side bus bridge sitting directly downstream of the core's MEM stage.
//  Turns one load/store request (req/we/addr/wdata/wmask) into a single AXI4-Lite
//  read or write transaction, and returns rdata plus the stall and err signals.
//  The core holds its MEM stage while core_stall=1. One transaction outstanding max.
// PARAMETERS
//  ADDR_W      32      AXI and core address width
//  AXI_PROT    3'b000  constant driven on m_awprot / m_arprot
//  ALIGN_ADDR  1       1: force m_awaddr[1:0] / m_araddr[1:0] = 2'b00; 0: pass through
// PORTS
//  clk          in   1       clock
//  reset        in   1       asynchronous, active-high reset
//  core_req     in   1       request pulse, sampled only in IDLE
//  core_we      in   1       1=store, 0=load
//  core_addr    in   ADDR_W  byte address
//  core_wdata   in   32      store data, already lane-aligned
//  core_wmask   in   4       store byte strobes
//  core_rdata   out  32      load data, registered
//  core_done    out  1       1-cycle pulse: transaction completed
//  core_err     out  1       1-cycle pulse with core_done when RESP[1]=1 (SLVERR/DECERR)
//  core_stall   out  1       high while a transaction is in flight
//  m_aw*        out  awaddr[ADDR_W], awprot[3], awvalid[1]; in awready[1]
//  m_w*         out  wdata[32], wstrb[4], wvalid[1];        in wready[1]
//  m_b*         in   bresp[2], bvalid[1];                   out bready[1]
//  m_ar*        out  araddr[ADDR_W], arprot[3], arvalid[1]; in arready[1]
//  m_r*         in   rdata[32], rresp[2], rvalid[1];        out rready[1]
// BEHAVIOUR
//  Reset: state=IDLE; all valid/ready outputs, core_stall/done/err = 0; core_rdata=0.
//   Registered address and data outputs = 0. Reset mid-transaction drops it silently.
//  FSM states: IDLE, WADDR, WRESP, RADDR, RDATA. core_stall = (state != IDLE).
//  IDLE:
//   - core_req=1 at an edge: latch addr, wdata, wmask.
//   - Next state is WADDR if core_we=1, RADDR if core_we=0.
//   - Clear aw_done and w_done.
//  WADDR:
//   - m_awvalid = !aw_done; m_wvalid = !w_done.
//   - Each flag sets on its own handshake; AW and W handshakes are independent.
//   - Go to WRESP at the edge where both flags are done, including when both handshakes
//     occur in the same cycle or one is already done.
//  WRESP: m_bready=1. On bvalid go to IDLE; core_done=1 and core_err=bresp[1] next cycle.
//  RADDR: m_arvalid=1 until arready, then RDATA.
//  RDATA:
//   - m_rready=1. On rvalid: core_rdata <= m_rdata, go to IDLE.
//   - core_done=1 and core_err=rresp[1] next cycle.
//   - core_rdata is updated even on error.
//  Valid hold: once asserted, a VALID stays high and its payload stays stable until
//   its READY; there is no combinational path from any READY to any VALID.
//  Minimum latency with zero-wait slave:
//   - read: req edge T0; arvalid in T0..T1; RDATA in T1..T2; done in T2..T3.
//     Stall covers 2 cycles.
//   - write: stall covers 2 cycles (WADDR, WRESP).
//  core_req while core_stall=1 is ignored; no queueing.
//   A request in the first IDLE cycle, the one carrying core_done, is accepted as new.
//  core_wmask is not driven to AXI on reads. m_wstrb = latched mask; wmask=0 is a legal write.
// TESTING
//  1. Read, zero-wait slave, addr 0x1004, rdata 0xDEADBEEF, rresp 0:
//     arvalid 1 cycle, stall 2 cycles, core_rdata=0xDEADBEEF, done=1, err=0.
//  2. Write 0x1000, wdata 0xA5A5A5A5, mask 4'b0011; awready 3 cycles late, wready immediate:
//     wvalid 1 cycle, awvalid held 4 cycles with stable awaddr, wstrb=4'b0011, single done.
//  3. Write with AW and W ready in the same cycle, then bresp=2'b10:
//     go directly to WRESP; done=1 and err=1 in the same cycle.
//  4. Load at 0x2003 with ALIGN_ADDR=1 -> m_araddr=0x2000.
//     Req pulses during stall -> no extra AR handshake.
//  5. Back-to-back: new req in the done cycle -> second transaction starts.
//     Assert reset while in RDATA -> all valids and readys 0, stall 0, state IDLE.

Source files
------------

// File: rtl/data_axil_master.sv
// data_axil_master
//   Data-side bridge behind the core's MEM stage. Each accepted load or store
//   request becomes exactly one AXI4-Lite read or write. Only one transaction
//   is in flight at a time, and the core is held by core_stall until it ends.
//
// States
//   IDLE  | waiting for core_req; the cycle carrying core_done is also IDLE
//   WADDR | presenting AW and W; each channel retires independently
//   WRESP | waiting for the write response on B
//   RADDR | presenting AR until arready
//   RDATA | waiting for read data on R
//
// Ports
//   clk, reset                 clock and asynchronous active-high reset
//   core_req/we/addr/wdata/wmask   request from the MEM stage
//   core_rdata                 registered load data (updated even on error)
//   core_done, core_err        one-cycle completion and error pulses
//   core_stall                 high while a transaction is in flight
//   m_aw*, m_w*, m_b*          AXI4-Lite write channels
//   m_ar*, m_r*                AXI4-Lite read channels
module data_axil_master #(
    parameter int          ADDR_W     = 32,
    parameter logic [2:0]  AXI_PROT   = 3'b000,
    parameter bit          ALIGN_ADDR = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [31:0]       core_wdata,
    input  logic [3:0]        core_wmask,
    output logic [31:0]       core_rdata,
    output logic              core_done,
    output logic              core_err,
    output logic              core_stall,
    output logic [ADDR_W-1:0] m_awaddr,
    output logic [2:0]        m_awprot,
    output logic              m_awvalid,
    input  logic              m_awready,
    output logic [31:0]       m_wdata,
    output logic [3:0]        m_wstrb,
    output logic              m_wvalid,
    input  logic              m_wready,
    input  logic [1:0]        m_bresp,
    input  logic              m_bvalid,
    output logic              m_bready,
    output logic [ADDR_W-1:0] m_araddr,
    output logic [2:0]        m_arprot,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [31:0]       m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rvalid,
    output logic              m_rready
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WADDR = 3'd1;
    localparam logic [2:0] S_WRESP = 3'd2;
    localparam logic [2:0] S_RADDR = 3'd3;
    localparam logic [2:0] S_RDATA = 3'd4;

    logic [2:0]        state;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wmask_q;
    logic              aw_done;
    logic              w_done;
    logic [ADDR_W-1:0] bus_addr;
    logic              aw_next;
    logic              w_next;

    // Only RESP[1] distinguishes an error; the low bits are intentionally ignored.
    logic unused_resp_lsb;
    assign unused_resp_lsb = m_bresp[0] ^ m_rresp[0];

    // Payloads and VALIDs come only from registered state, so no READY can
    // reach a VALID combinationally and payloads hold until their handshake.
    assign bus_addr   = ALIGN_ADDR ? {addr_q[ADDR_W-1:2], 2'b00} : addr_q;
    assign m_awaddr   = bus_addr;
    assign m_araddr   = bus_addr;
    assign m_awprot   = AXI_PROT;
    assign m_arprot   = AXI_PROT;
    assign m_wdata    = wdata_q;
    assign m_wstrb    = wmask_q;

    assign m_awvalid  = (state == S_WADDR) && !aw_done;
    assign m_wvalid   = (state == S_WADDR) && !w_done;
    assign m_bready   = (state == S_WRESP);
    assign m_arvalid  = (state == S_RADDR);
    assign m_rready   = (state == S_RDATA);
    assign core_stall = (state != S_IDLE);

    // A channel counts as done if it retired earlier or retires this cycle;
    // this covers both handshakes landing together.
    assign aw_next = aw_done || (m_awvalid && m_awready);
    assign w_next  = w_done  || (m_wvalid  && m_wready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            core_rdata <= '0;
            core_done  <= 1'b0;
            core_err   <= 1'b0;
        end else begin
            core_done <= 1'b0;
            core_err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (core_req) begin
                        addr_q  <= core_addr;
                        wdata_q <= core_wdata;
                        wmask_q <= core_wmask;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        state   <= core_we ? S_WADDR : S_RADDR;
                    end
                end
                S_WADDR: begin
                    aw_done <= aw_next;
                    w_done  <= w_next;
                    if (aw_next && w_next) begin
                        state <= S_WRESP;
                    end
                end
                S_WRESP: begin
                    if (m_bvalid) begin
                        core_done <= 1'b1;
                        core_err  <= m_bresp[1];
                        state     <= S_IDLE;
                    end
                end
                S_RADDR: begin
                    if (m_arready) begin
                        state <= S_RDATA;
                    end
                end
                S_RDATA: begin
                    if (m_rvalid) begin
                        core_rdata <= m_rdata;
                        core_done  <= 1'b1;
                        core_err   <= m_rresp[1];
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
